// File: rtl/cache_perf_counter_ctrl.sv
// Cache performance counter bank with START/STOP/CLEAR/SNAPSHOT command control.
// Optional macro CACHE_PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module cache_perf_counter_ctrl #(
  parameter int XLEN          = 32,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            event_valid,
  input  logic            event_hit,
  input  logic            event_is_write,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_op,
  output logic            cmd_ready,
  output logic [XLEN-1:0] hit_value,
  output logic [XLEN-1:0] miss_value,
  output logic [XLEN-1:0] read_value,
  output logic [XLEN-1:0] write_value,
  output logic            running,
  output logic [3:0]      overflow
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_CLEARING = 2'b10
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SNAP  = 2'b11;

  localparam logic [XLEN-1:0] CNT_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] CNT_ONE  = {{(XLEN-1){1'b0}}, 1'b1};

  // Counter index order matches overflow bit order: {write, read, miss, hit}.
  function automatic logic [XLEN-1:0] cnt_step(input logic [XLEN-1:0] v, input logic inc);
    logic [XLEN-1:0] res;
    res = v;
`ifdef CACHE_PERF_SATURATE_EN
    if (inc && !(&v)) begin
      res = v + CNT_ONE;
    end else begin
      res = v;
    end
`else
    if (inc) begin
      res = v + CNT_ONE;
    end else begin
      res = v;
    end
`endif
    return res;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ret_run;
  logic            w_ret_run_nxt;
  logic [XLEN-1:0] r_cnt     [4];
  logic [XLEN-1:0] w_cnt_nxt [4];
  logic [XLEN-1:0] r_val     [4];
  logic [3:0]      r_ovf;
  logic [3:0]      w_ovf_nxt;
  logic [3:0]      w_inc;
  logic [3:0]      w_all_ones;
  logic            w_cmd_acc;
  logic            w_clr;
  logic            w_snap;
  logic            w_count;

  assign cmd_ready   = (r_state != ST_CLEARING);
  assign running     = (r_state == ST_RUN);
  assign w_cmd_acc   = cmd_valid && cmd_ready;
  assign w_clr       = w_cmd_acc && (cmd_op == OP_CLEAR);
  assign w_snap      = w_cmd_acc && (cmd_op == OP_SNAP);
  // A CLEAR accepted in RUN drops the event of the same cycle.
  assign w_count     = event_valid && (r_state == ST_RUN) && !w_clr;
  assign w_inc       = {w_count && event_is_write, w_count && !event_is_write,
                        w_count && !event_hit,     w_count && event_hit};

  assign hit_value   = r_val[0];
  assign miss_value  = r_val[1];
  assign read_value  = r_val[2];
  assign write_value = r_val[3];
  assign overflow    = r_ovf;

  // Next-state and return-state selection for the command FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_ret_run_nxt = r_ret_run;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc && (cmd_op == OP_START)) begin
          w_state_nxt = ST_RUN;
        end else if (w_clr) begin
          w_ret_run_nxt = 1'b0;
          w_state_nxt   = ST_CLEARING;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_cmd_acc && (cmd_op == OP_STOP)) begin
          w_state_nxt = ST_IDLE;
        end else if (w_clr) begin
          w_ret_run_nxt = 1'b1;
          w_state_nxt   = ST_CLEARING;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_CLEARING: begin
        if (r_ret_run) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_ret_run_nxt = 1'b0;
      end
    endcase
  end

  // Counter and sticky-overflow next values.
  always_comb begin
    w_all_ones = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_all_ones[i] = &r_cnt[i];
      if (w_clr) begin
        w_cnt_nxt[i] = CNT_ZERO;
      end else begin
        w_cnt_nxt[i] = cnt_step(r_cnt[i], w_inc[i]);
      end
    end
    if (w_clr) begin
      w_ovf_nxt = 4'b0000;
    end else begin
      w_ovf_nxt = r_ovf | (w_inc & w_all_ones);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= START_RUNNING ? ST_RUN : ST_IDLE;
      r_ret_run <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ret_run <= w_ret_run_nxt;
    end
  end

  // Counters, overflow flags and snapshot registers; a snapshot captures next counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= CNT_ZERO;
        r_val[i] <= CNT_ZERO;
      end
      r_ovf <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        if (w_snap) begin
          r_val[i] <= w_cnt_nxt[i];
        end else begin
          r_val[i] <= r_val[i];
        end
      end
      r_ovf <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_cache_perf_counter_ctrl.sv
// Scoreboard bench for cache_perf_counter_ctrl (XLEN=4, START_RUNNING=0); follows CACHE_PERF_SATURATE_EN.
module tb_cache_perf_counter_ctrl;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SNAP  = 2'b11;

`ifdef CACHE_PERF_SATURATE_EN
  localparam logic [3:0] CNT17 = 4'd15;
`else
  localparam logic [3:0] CNT17 = 4'd1;
`endif

  typedef struct packed {
    logic [3:0] hit;
    logic [3:0] miss;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [3:0] ovf;
    logic       run;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       event_valid, event_hit, event_is_write, cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready, running;
  logic [3:0] hit_value, miss_value, read_value, write_value, overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  cache_perf_counter_ctrl #(.XLEN(4), .START_RUNNING(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .event_valid(event_valid), .event_hit(event_hit), .event_is_write(event_is_write),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .hit_value(hit_value), .miss_value(miss_value),
    .read_value(read_value), .write_value(write_value),
    .running(running), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic ev, input logic h, input logic w, input logic cv, input logic [1:0] op);
    @(negedge clk);
    event_valid    = ev;
    event_hit      = h;
    event_is_write = w;
    cmd_valid      = cv;
    cmd_op         = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input logic ev, input logic h, input logic w, input exp_t e);
    sb_q.push_back(e);
    drv(ev, h, w, 1'b1, OP_SNAP);
  endtask

  // Monitor: spots an accepted SNAPSHOT and compares the outputs one cycle later.
  initial begin
    logic pending;
    exp_t e;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending && reset_n) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL snapshot_unexpected actual=accepted required=none");
        end else begin
          e = sb_q.pop_front();
          chk("snap_hit",   hit_value,   e.hit);
          chk("snap_miss",  miss_value,  e.miss);
          chk("snap_read",  read_value,  e.rd);
          chk("snap_write", write_value, e.wr);
          chk("snap_ovf",   overflow,    e.ovf);
          chk("snap_run",   running,     e.run);
        end
      end
      #1;
      pending = reset_n && cmd_valid && cmd_ready && (cmd_op == OP_SNAP);
    end
  end

  initial begin
    reset_n = 1'b0;
    event_valid = 1'b0; event_hit = 1'b0; event_is_write = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00;
    #12;
    chk("rst_running", running, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_values", {hit_value, miss_value, read_value, write_value}, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // IDLE: events are ignored
    drv(1, 1, 0, 0, OP_START); drv(1, 0, 1, 0, OP_START);
    drv(1, 1, 1, 0, OP_START); drv(1, 0, 0, 0, OP_START);
    snap(0, 0, 0, '{hit:4'd0, miss:4'd0, rd:4'd0, wr:4'd0, ovf:4'd0, run:1'b0});

    // START then 5 events
    drv(0, 0, 0, 1, OP_START); tick();
    chk("start_running", running, 1);
    drv(1, 1, 1, 0, OP_START); drv(1, 1, 0, 0, OP_START); drv(1, 1, 0, 0, OP_START);
    drv(1, 0, 0, 0, OP_START); drv(1, 0, 0, 0, OP_START);
    snap(0, 0, 0, '{hit:4'd3, miss:4'd2, rd:4'd4, wr:4'd1, ovf:4'd0, run:1'b1});

    // STOP with an event: counted; START with an event in IDLE: dropped
    drv(1, 1, 1, 1, OP_STOP); tick();
    chk("stop_running", running, 0);
    snap(0, 0, 0, '{hit:4'd4, miss:4'd2, rd:4'd4, wr:4'd2, ovf:4'd0, run:1'b0});
    drv(1, 0, 0, 1, OP_START); tick();
    chk("restart_running", running, 1);

    // CLEAR with event, then event + blocked SNAPSHOT during CLEARING
    drv(1, 1, 0, 1, OP_CLEAR); tick();
    chk("clr_ready", cmd_ready, 0);
    chk("clr_running", running, 0);
    drv(1, 1, 0, 1, OP_SNAP); tick();
    chk("clr_done_ready", cmd_ready, 1);
    chk("clr_done_running", running, 1);
    chk("clr_keeps_snap", {hit_value, miss_value, read_value, write_value}, 16'h4242);
    drv(1, 0, 1, 0, OP_START); drv(1, 1, 0, 0, OP_START);
    snap(0, 0, 0, '{hit:4'd1, miss:4'd1, rd:4'd1, wr:4'd1, ovf:4'd0, run:1'b1});

    // SNAPSHOT coinciding with a write-miss, prior miss=7 write=2
    drv(0, 0, 0, 1, OP_CLEAR); drv(0, 0, 0, 0, OP_START);
    drv(1, 0, 1, 0, OP_START); drv(1, 0, 1, 0, OP_START);
    for (int i = 0; i < 5; i++) drv(1, 0, 0, 0, OP_START);
    snap(1, 0, 1, '{hit:4'd0, miss:4'd8, rd:4'd5, wr:4'd3, ovf:4'd0, run:1'b1});

    // 17 hit-reads on 4-bit counters
    drv(0, 0, 0, 1, OP_CLEAR); drv(0, 0, 0, 0, OP_START);
    for (int i = 0; i < 17; i++) drv(1, 1, 0, 0, OP_START);
    snap(0, 0, 0, '{hit:CNT17, miss:4'd0, rd:CNT17, wr:4'd0, ovf:4'b0101, run:1'b1});

    // CLEAR zeroes overflow; reset asserted mid-CLEARING with a command pending
    drv(0, 0, 0, 1, OP_CLEAR); tick();
    chk("clr_ovf", overflow, 0);
    chk("clr2_ready", cmd_ready, 0);
    @(negedge clk);
    event_valid = 1'b1; cmd_valid = 1'b1; cmd_op = OP_START;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_values", {hit_value, miss_value, read_value, write_value}, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_running", running, 0);
    chk("arst_ready", cmd_ready, 1);
    @(negedge clk);
    event_valid = 1'b0; cmd_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_rst_running", running, 0);
    chk("post_rst_ready", cmd_ready, 1);
    snap(0, 0, 0, '{hit:4'd0, miss:4'd0, rd:4'd0, wr:4'd0, ovf:4'd0, run:1'b0});
    drv(0, 0, 0, 0, OP_START);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
